// File: rtl/auth_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : auth_sched_pkg                                             |
// | Shared state encoding, default geometry and width helper for the     |
// | constant-time credential compare scheduler.                          |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package auth_sched_pkg;

  localparam int DEF_HASH_W     = 32;
  localparam int DEF_SLICE_W    = 4;
  localparam int COMPARE_CYCLES = DEF_HASH_W / DEF_SLICE_W;

  // Scheduler state encoding: IDLE -> COMPARE -> RESPOND -> IDLE
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_COMPARE = 2'd1;
  localparam state_t ST_RESPOND = 2'd2;

  // Bits needed to hold the values 0..n-1 (never less than one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/auth_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : auth_rr_arbiter                                            |
// | Rotating-priority one-hot arbiter. Masked requesters are skipped;    |
// | the search start advances past the winner on every grant.            |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module auth_rr_arbiter
  import auth_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = cnt_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] mask_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      gidx_o
);

  logic [IW-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0] w_elig;
  logic               w_found;
  int                 w_j;

  assign w_elig = req_i & ~mask_i;

  // First eligible requester at or after the pointer wins; the grant is the handshake.
  always_comb begin
    gnt_o   = '0;
    gidx_o  = '0;
    ptr_d   = ptr_q;
    w_found = 1'b0;
    w_j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_j = (int'(ptr_q) + k) % NUM_REQ;
      if (!w_found && en_i && w_elig[w_j]) begin
        w_found    = 1'b1;
        gnt_o[w_j] = 1'b1;
        gidx_o     = IW'(w_j);
        ptr_d      = (w_j == NUM_REQ - 1) ? '0 : IW'(w_j + 1);
      end
    end
  end

  // Search-start pointer register.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule
`default_nettype wire

// File: rtl/auth_compare_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : auth_compare_scheduler                                     |
// | Shares one constant-time slice-serial hash comparator among NUM_REQ  |
// | round-robin requesters. Every compare takes HASH_W/SLICE_W cycles.   |
// | Optional build macro: AUTH_LOCKOUT_EN (per-requester fail lockout).  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module auth_compare_scheduler
  import auth_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int HASH_W      = DEF_HASH_W,
  parameter int SLICE_W     = DEF_SLICE_W,
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_we,
  input  logic [HASH_W-1:0]         cfg_hash,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*HASH_W-1:0] req_hash,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic                      resp_pass,
  output logic                      busy,
  output logic [NUM_REQ-1:0]        locked
);

  localparam int C  = HASH_W / SLICE_W;
  localparam int CW = cnt_w(C);
  localparam int IW = cnt_w(NUM_REQ);

  // Parameter sanity hooks: an illegal configuration elaborates an empty marker block.
  if ((HASH_W % SLICE_W) != 0) begin : g_bad_slice_w
  end
  if (MAX_FAILS < 1 || LOCK_CYCLES < 1) begin : g_bad_lock_params
  end

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              acc_q, acc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [HASH_W-1:0] cand_q, cand_d;
  logic [HASH_W-1:0] stored_q, stored_d;

  logic [NUM_REQ-1:0] w_gnt;
  logic [IW-1:0]      w_gidx;
  logic               w_grant_en;
  logic               w_hs;
  logic               w_slice_ne;

  // Grants only in IDLE; a config write wins over a grant in the same cycle.
  assign w_grant_en = (state_q == ST_IDLE) && !cfg_we && !reset;
  assign w_hs       = |w_gnt;
  assign req_ready  = w_gnt;
  assign busy       = (state_q != ST_IDLE);
  assign w_slice_ne = |(cand_q[int'(cnt_q)*SLICE_W +: SLICE_W] ^
                        stored_q[int'(cnt_q)*SLICE_W +: SLICE_W]);

  auth_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req_i  (req_valid),
    .mask_i (locked),
    .en_i   (w_grant_en),
    .gnt_o  (w_gnt),
    .gidx_o (w_gidx)
  );

  // Next-state: fixed-length compare, no data-dependent control anywhere.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    cand_d   = cand_q;
    stored_d = stored_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_we) begin
          stored_d = cfg_hash;
        end else if (w_hs) begin
          idx_d   = w_gidx;
          cand_d  = req_hash[int'(w_gidx)*HASH_W +: HASH_W];
          acc_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        acc_d = acc_q | w_slice_ne;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(C - 1)) state_d = ST_RESPOND;
      end
      ST_RESPOND: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= 1'b0;
      idx_q    <= '0;
      cand_q   <= '0;
      stored_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      cand_q   <= cand_d;
      stored_q <= stored_d;
    end
  end

  // Response pulse to the latched requester; pass is forced low outside it.
  always_comb begin
    resp_valid = '0;
    resp_pass  = 1'b0;
    if (state_q == ST_RESPOND) begin
      resp_valid[idx_q] = 1'b1;
      resp_pass         = ~acc_q;
    end
  end

`ifdef AUTH_LOCKOUT_EN
  localparam int FW = cnt_w(MAX_FAILS + 1);
  localparam int LW = cnt_w(LOCK_CYCLES + 1);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lock
    logic [FW-1:0] fail_q, fail_d;
    logic          lock_q, lock_d;
    logic [LW-1:0] lcnt_q, lcnt_d;

    // Fail counting on this requester's responses; lock countdown while locked.
    always_comb begin
      fail_d = fail_q;
      lock_d = lock_q;
      lcnt_d = lcnt_q;
      if (lock_q) begin
        if (lcnt_q == LW'(1)) begin
          lock_d = 1'b0;
          lcnt_d = '0;
        end else begin
          lcnt_d = lcnt_q - LW'(1);
        end
      end else if (resp_valid[i]) begin
        if (resp_pass) begin
          fail_d = '0;
        end else if (fail_q >= FW'(MAX_FAILS - 1)) begin
          lock_d = 1'b1;
          fail_d = '0;
          lcnt_d = LW'(LOCK_CYCLES);
        end else begin
          fail_d = fail_q + FW'(1);
        end
      end
    end

    // Per-requester lockout registers.
    always_ff @(posedge clk) begin
      if (reset) begin
        fail_q <= '0;
        lock_q <= 1'b0;
        lcnt_q <= '0;
      end else begin
        fail_q <= fail_d;
        lock_q <= lock_d;
        lcnt_q <= lcnt_d;
      end
    end

    assign locked[i] = lock_q;
  end
`else
  assign locked = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_auth_compare_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_auth_compare_scheduler                                  |
// | Self-checking bench for auth_compare_scheduler with a transaction    |
// | level reference model (honours AUTH_LOCKOUT_EN when defined).        |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_auth_compare_scheduler;
  import auth_sched_pkg::*;

  localparam int NUM_REQ     = 4;
  localparam int HASH_W      = 32;
  localparam int SLICE_W     = 4;
  localparam int MAX_FAILS   = 3;
  localparam int LOCK_CYCLES = 256;
  localparam int LAT         = COMPARE_CYCLES + 1;
`ifdef AUTH_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      cfg_we;
  logic [HASH_W-1:0]         cfg_hash;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*HASH_W-1:0] req_hash;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        resp_valid;
  logic                      resp_pass;
  logic                      busy;
  logic [NUM_REQ-1:0]        locked;

  auth_compare_scheduler #(
    .NUM_REQ     (NUM_REQ),
    .HASH_W      (HASH_W),
    .SLICE_W     (SLICE_W),
    .MAX_FAILS   (MAX_FAILS),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_we     (cfg_we),
    .cfg_hash   (cfg_hash),
    .req_valid  (req_valid),
    .req_hash   (req_hash),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_pass  (resp_pass),
    .busy       (busy),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;

  // Reference model: stored credential, next search start, fail/lock bookkeeping.
  logic [HASH_W-1:0] m_stored;
  int                m_ptr;
  int                m_fails    [NUM_REQ];
  int unsigned       m_lock_end [NUM_REQ];

  function automatic logic [NUM_REQ-1:0] m_locked();
    logic [NUM_REQ-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_REQ; i++) r[i] = LOCK_EN && (cyc < m_lock_end[i]);
    return r;
  endfunction

  function automatic logic [NUM_REQ-1:0] oh(input int w);
    logic [NUM_REQ-1:0] r;
    r = '0;
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  function automatic logic [NUM_REQ*HASH_W-1:0] put(input logic [NUM_REQ*HASH_W-1:0] b,
                                                    input int i, input logic [HASH_W-1:0] v);
    logic [NUM_REQ*HASH_W-1:0] r;
    r = b;
    r[i*HASH_W +: HASH_W] = v;
    return r;
  endfunction

  function automatic logic [NUM_REQ*HASH_W-1:0] rand_hashes();
    logic [NUM_REQ*HASH_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_REQ; i++) r[i*HASH_W +: HASH_W] = HASH_W'($urandom);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [HASH_W-1:0] obs, input logic [HASH_W-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_stored = '0;
    m_ptr    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      m_fails[i]    = 0;
      m_lock_end[i] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; cfg_we = 1'b0; req_valid = '1; req_hash = '0; cfg_hash = '0;
    #1;
    chk("ready_in_reset", HASH_W'(req_ready), '0);
    @(negedge clk);
    reset = 1'b0; req_valid = '0;
    model_reset();
    #1;
    chk("rst_busy", HASH_W'(busy), '0);
    chk("rst_resp_valid", HASH_W'(resp_valid), '0);
    chk("rst_resp_pass", HASH_W'(resp_pass), '0);
    chk("rst_locked", HASH_W'(locked), '0);
    chk("rst_ready", HASH_W'(req_ready), '0);
  endtask

  // Config write in an IDLE cycle, optionally racing a request in the same cycle.
  task automatic cfg_write(input logic [HASH_W-1:0] h, input logic [NUM_REQ-1:0] v);
    @(negedge clk);
    cfg_we = 1'b1; cfg_hash = h; req_valid = v;
    #1;
    chk("cfg_prio_ready", HASH_W'(req_ready), '0);
    m_stored = h;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  // One arbitration cycle plus, when granted, the full compare and response.
  task automatic txn(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ*HASH_W-1:0] h,
                     input bit mid_cfg);
    int                 w;
    int                 lat;
    int                 j;
    bit                 done;
    bit                 bad;
    bit                 pass;
    logic [NUM_REQ-1:0] el;
    @(negedge clk);
    req_valid = v; req_hash = h; cfg_we = 1'b0;
    #1;
    el = v & ~m_locked();
    chk("locked", HASH_W'(locked), HASH_W'(m_locked()));
    w = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (m_ptr + k) % NUM_REQ;
      if (w < 0 && el[j]) w = j;
    end
    chk("grant", HASH_W'(req_ready), HASH_W'(oh(w)));
    if (w < 0) return;
    pass  = (h[w*HASH_W +: HASH_W] == m_stored);
    m_ptr = (w + 1) % NUM_REQ;
    @(posedge clk);
    #1;
    req_hash = rand_hashes();
    lat = 0; done = 1'b0; bad = 1'b0;
    while (!done && lat < LAT + 6) begin
      @(negedge clk);
      lat++;
      if (resp_valid != '0) begin
        done = 1'b1;
      end else begin
        if (req_ready != '0 || busy !== 1'b1 || resp_pass !== 1'b0) bad = 1'b1;
      end
      cfg_we = (mid_cfg && lat == 3);
      cfg_hash = HASH_W'($urandom);
    end
    cfg_we = 1'b0;
    chk("compare_phase_outputs", HASH_W'(bad), '0);
    chk("latency", HASH_W'(lat), HASH_W'(LAT));
    chk("resp_idx", HASH_W'(resp_valid), HASH_W'(oh(w)));
    chk("resp_pass", HASH_W'(resp_pass), HASH_W'(pass));
    chk("busy_resp", HASH_W'(busy), 1);
    if (LOCK_EN) begin
      if (pass) m_fails[w] = 0;
      else begin
        m_fails[w]++;
        if (m_fails[w] >= MAX_FAILS) begin
          m_fails[w]    = 0;
          m_lock_end[w] = cyc + 1 + LOCK_CYCLES;
        end
      end
    end
  endtask

  initial begin
    logic [NUM_REQ*HASH_W-1:0] h;
    logic [NUM_REQ-1:0]        v;
    int                        guard;
    reset = 1'b1; cfg_we = 1'b0; cfg_hash = '0; req_valid = '0; req_hash = '0;
    model_reset();
    do_reset();

    // Directed pass / MSB mismatch / LSB mismatch, identical latency.
    cfg_write(32'hDEADBEEF, '0);
    txn(4'b0001, put('0, 0, 32'hDEADBEEF), 1'b0);
    txn(4'b0010, put('0, 1, 32'h5EADBEEF), 1'b0);
    txn(4'b0010, put('0, 1, 32'hDEADBEEE), 1'b0);

    // All requesters valid continuously: rotation 0,1,2,3,0 from reset.
    do_reset();
    cfg_write(32'hDEADBEEF, '0);
    h = '0;
    for (int i = 0; i < NUM_REQ; i++) h = put(h, i, 32'hDEADBEEF);
    for (int n = 0; n < 5; n++) txn(4'hF, h, 1'b0);

    // Config write racing a request, then a config write during COMPARE.
    cfg_write(32'hCAFEF00D, 4'b0010);
    txn(4'b0010, put('0, 1, 32'hCAFEF00D), 1'b1);
    txn(4'b0100, put('0, 2, 32'hCAFEF00D), 1'b0);

    // Reset three cycles into COMPARE abandons the comparison.
    @(negedge clk);
    req_valid = 4'b1000; req_hash = put('0, 3, m_stored);
    #1;
    chk("pre_abort_grant", HASH_W'(req_ready), HASH_W'(oh(3)));
    repeat (3) @(negedge clk);
    reset = 1'b1; req_valid = 4'hF;
    #1;
    chk("abort_ready_in_reset", HASH_W'(req_ready), '0);
    @(negedge clk);
    reset = 1'b0; req_valid = '0;
    model_reset();
    #1;
    chk("abort_busy", HASH_W'(busy), '0);
    chk("abort_resp_valid", HASH_W'(resp_valid), '0);
    chk("abort_resp_pass", HASH_W'(resp_pass), '0);
    chk("abort_locked", HASH_W'(locked), '0);
    v = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      v = v | resp_valid;
    end
    chk("abort_no_response", HASH_W'(v), '0);

    // Requester 2 fails repeatedly; lockout (when built) holds it off.
    cfg_write(32'h13579BDF, '0);
    for (int n = 0; n < MAX_FAILS; n++) txn(4'b0100, put('0, 2, 32'h13579BDE), 1'b0);
    guard = 0;
    while (m_locked() != '0 && guard < LOCK_CYCLES + 20) begin
      txn(4'b0100, put('0, 2, 32'h13579BDF), 1'b0);
      guard++;
    end
    txn(4'b0100, put('0, 2, 32'h13579BDF), 1'b0);

    // Randomised traffic against the model.
    for (int n = 0; n < 40; n++) begin
      if (n % 5 == 0) cfg_write(HASH_W'($urandom), NUM_REQ'($urandom));
      v = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      h = rand_hashes();
      for (int i = 0; i < NUM_REQ; i++) if ($urandom_range(0, 1) == 1) h = put(h, i, m_stored);
      txn(v, h, ($urandom_range(0, 3) == 0));
    end

    @(negedge clk);
    req_valid = '0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
